fb_pixel_sink: RTL
==================

// Module: fb_pixel_sink
// PURPOSE
//  Framebuffer-side receiver for pixel write requests from the drawing units
//  (x, y, colour, writeEn). It buffers requests in a FIFO and drains them into
//  the VGA framebuffer RAM write port as linear address and data, one pixel per
//  granted cycle. It sits between the drawing-unit mux and the VGA adapter memory.
// PARAMETERS
//  DEPTH     16   FIFO entries (power of 2, >=2)
//  SCREEN_W  320  framebuffer width in pixels
//  SCREEN_H  240  framebuffer height in pixels
//  ADDR_W    17   framebuffer address width
//  COLOUR_W  3    colour bits per pixel
// PORTS
//  clk         in   1         system clock, rising edge
//  resetn      in   1         asynchronous active-low reset
//  x_in        in   9         pixel x
//  y_in        in   8         pixel y
//  colour_in   in   COLOUR_W  pixel colour
//  writeEn     in   1         pixel request valid, one pixel per cycle
//  ready       out  1         request accepted this cycle if writeEn=1
//  fb_grant    in   1         framebuffer port available this cycle
//  fb_address  out  ADDR_W    framebuffer write address
//  fb_data     out  COLOUR_W  framebuffer write data
//  fb_wren     out  1         framebuffer write strobe
//  flush_req   in   1         single-cycle pulse: drain FIFO, then signal done
//  flush_done  out  1         single-cycle pulse when flush completes
//  level       out  $clog2(DEPTH)+1  current FIFO occupancy
//  overflow    out  1         sticky: a request was dropped while the FIFO was full
// BEHAVIOUR
//  - Reset (async, resetn=0): FIFO empty, level=0, ready=1, fb_wren=0,
//    fb_address=0, fb_data=0, flush_done=0, overflow=0, state=S_IDLE.
//    Reset mid-drain discards all entries; no partial write is issued.
//  - Push: writeEn && ready. ready = !full && state!=S_FLUSH.
//    writeEn && full: request dropped, overflow<=1 until reset.
//    writeEn in S_FLUSH while not full: dropped, overflow unchanged.
//  - Pop: fb_grant && !empty. Pop at edge k: fb_wren=1 for cycle k..k+1, with
//    fb_address = y*SCREEN_W + x (unsigned, computed in ADDR_W bits) and
//    fb_data = colour. Otherwise fb_wren=0; address/data hold.
//  - Latency: push into an empty FIFO at edge k, fb_grant=1 -> fb_wren high
//    after edge k+1. Order is strictly FIFO. Sustained throughput is 1 pixel/clk.
//  - Simultaneous push and pop: both occur, level unchanged. Full with pop
//    pending: push is still refused (ready depends on full only).
//  - Pointers wrap modulo DEPTH; full = level==DEPTH; empty = level==0.
//  - FSM: S_IDLE -(flush_req)-> S_FLUSH -(empty && no pop this cycle)->
//    S_DONE -> S_IDLE. flush_done=1 only in S_DONE. flush_req in S_FLUSH or
//    S_DONE is ignored. flush_req when already empty: S_FLUSH for one cycle,
//    then S_DONE.
// CONFIGURATION
//  FB_SINK_CLIP_EN defined: at push, requests with x_in>=SCREEN_W or
//    y_in>=SCREEN_H are consumed (ready honoured) but not stored; they do not
//    affect level or overflow.
//  FB_SINK_CLIP_EN undefined: all requests are stored; out-of-range
//    coordinates produce addresses above SCREEN_W*SCREEN_H-1 (max 82111, fits
//    in 17 bits), which are written as is.
// STRUCTURE
//  - Package fb_pkg: SCREEN_W, SCREEN_H, ADDR_W, COLOUR_W constants;
//    pixel_t typedef {x[8:0], y[7:0], colour}; FSM state enum
//    (S_IDLE, S_FLUSH, S_DONE).
//  - Sub-module fb_pixel_fifo: synchronous FIFO of pixel_t with push/pop/
//    full/empty/level. The top level holds the FSM, address multiply-add and
//    output registers.
// TESTING
//  1. Reset, push (x=5,y=2,c=3'b101) with grant=1 -> fb_wren one cycle later,
//     fb_address=645, fb_data=5.
//  2. grant=0, push 16 pixels, then a 17th -> ready=0 at 16, overflow=1,
//     level=16. Grant=1 -> 16 writes in order, level returns to 0.
//  3. Continuous push and grant for 100 cycles -> level constant, 100
//     consecutive fb_wren, addresses match.
//  4. Load 4 entries, flush_req -> ready=0, 4 writes, flush_done pulses one
//     cycle after the last pop, ready=1 again.
//  5. Push (319,239) -> address 76799. Push (400,10): CLIP_EN -> no write;
//     without CLIP_EN -> address 3600.
//  6. Deassert resetn with 8 entries during a drain -> fb_wren=0 immediately,
//     level=0. After release, no stale writes occur.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer-sink types: screen geometry, the queued pixel record
// and the flush state encoding.
package fb_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;
    localparam int COLOUR_W = 3;

    typedef struct packed {
        logic [8:0]          x;
        logic [7:0]          y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Synchronous pixel FIFO with a first-word-fall-through read port.
// The caller only pushes when not full and only pops when not empty.
module fb_pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  pixel_t                 wdata,
    output pixel_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    pixel_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   cnt;

    // Storage carries no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == LVL_W'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/fb_pixel_sink.sv
// Buffers drawing-unit pixel requests and drains them into the framebuffer
// write port. Define FB_SINK_CLIP_EN to discard off-screen requests at push.
module fb_pixel_sink
    import fb_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int COLOUR_W = fb_pkg::COLOUR_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [8:0]             x_in,
    input  logic [7:0]             y_in,
    input  logic [COLOUR_W-1:0]    colour_in,
    input  logic                   writeEn,
    output logic                   ready,
    input  logic                   fb_grant,
    output logic [ADDR_W-1:0]      fb_address,
    output logic [COLOUR_W-1:0]    fb_data,
    output logic                   fb_wren,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    state_t                 state;
    logic                   full;
    logic                   empty;
    logic                   in_range;
    logic                   push;
    logic                   pop;
    pixel_t                 wr_pix;
    pixel_t                 head_pix;
    logic                   vld_p1;
    logic [ADDR_W-1:0]      addr_p1;
    logic [COLOUR_W-1:0]    data_p1;
    logic                   done_q;
    logic                   ovf_q;

    // Linear framebuffer address; wraps within ADDR_W bits by construction.
    function automatic logic [ADDR_W-1:0] lin_addr(input pixel_t p);
        return ADDR_W'(p.y) * ADDR_W'(SCREEN_W) + ADDR_W'(p.x);
    endfunction

`ifdef FB_SINK_CLIP_EN
    assign in_range = (32'(x_in) < SCREEN_W) && (32'(y_in) < SCREEN_H);
`else
    assign in_range = 1'b1;
`endif

    assign ready  = !full && (state != S_FLUSH);
    assign push   = writeEn && ready && in_range;
    assign pop    = fb_grant && !empty;
    assign wr_pix = '{x: x_in, y: y_in, colour: colour_in};

    fb_pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (wr_pix),
        .rdata  (head_pix),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // Stage p1: popped head becomes the registered framebuffer write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                addr_p1 <= lin_addr(head_pix);
                data_p1 <= head_pix.colour;
            end
        end
    end

    // Flush sequencing plus the sticky drop flag; only in-range drops count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (writeEn && full && in_range) begin
                ovf_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (flush_req) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (empty && !pop) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fb_wren    = vld_p1;
    assign fb_address = addr_p1;
    assign fb_data    = data_p1;
    assign flush_done = done_q;
    assign overflow   = ovf_q;

endmodule
